// File: rtl/keynsham_dbus_pkg.sv
// keynsham_dbus_pkg: shared encodings, FSM state type and defaults for the
// Keynsham data-bus master. The optional timeout counter in the master is
// enabled with the KEYNSHAM_DBUS_TIMEOUT_EN macro.
package keynsham_dbus_pkg;

  // Request width encodings
  localparam logic [1:0] DBUS_BYTE = 2'b00;
  localparam logic [1:0] DBUS_HALF = 2'b01;
  localparam logic [1:0] DBUS_WORD = 2'b10;
  localparam logic [1:0] DBUS_RSVD = 2'b11;

  // Default number of unacknowledged ACCESS cycles before abort
  localparam int unsigned DBUS_TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } dbus_state_t;

endpackage

// File: rtl/keynsham_dbus_if.sv
// keynsham_dbus_if: request/response handshake and d_* bus signals of the
// Keynsham data-bus master. The master modport is the block's own view; the
// slave modport is the view of the execute/writeback stages and responders.
interface keynsham_dbus_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [31:0] req_addr;
  logic [1:0]  req_width;
  logic        req_signed;
  logic [31:0] req_wr_val;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        d_access;
  logic [31:0] d_addr;
  logic [3:0]  d_bytesel;
  logic [31:0] d_wr_val;
  logic        d_wr_en;
  logic [31:0] d_data;
  logic        d_ack;

  modport master (
    input  req_valid, req_wr, req_addr, req_width, req_signed, req_wr_val,
    input  d_data, d_ack,
    output req_ready, rsp_valid, rsp_data, rsp_err,
    output d_access, d_addr, d_bytesel, d_wr_val, d_wr_en
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_width, req_signed, req_wr_val,
    output d_data, d_ack,
    input  req_ready, rsp_valid, rsp_data, rsp_err,
    input  d_access, d_addr, d_bytesel, d_wr_val, d_wr_en
  );

endinterface

// File: rtl/keynsham_dbus_lanes.sv
// keynsham_dbus_lanes: purely combinational little-endian lane logic. Produces
// byte enables, lane-replicated store data, extracted and extended load data
// and an alignment fault flag. The reserved width yields all-zero outputs and
// is flagged by the caller.
module keynsham_dbus_lanes
  import keynsham_dbus_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  logic [1:0]  i_width,
  input  logic        i_signed,
  input  logic [31:0] i_wr_val,
  input  logic [31:0] i_rd_data,
  output logic [3:0]  o_bytesel,
  output logic [31:0] o_wr_val,
  output logic [31:0] o_rd_val,
  output logic        o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection, replication and extension by access width
  always_comb begin
    o_bytesel  = 4'b0000;
    o_wr_val   = '0;
    o_rd_val   = '0;
    o_misalign = 1'b0;
    w_half     = i_addr_lo[1] ? i_rd_data[31:16] : i_rd_data[15:0];
    case (i_addr_lo)
      2'd0:    w_byte = i_rd_data[7:0];
      2'd1:    w_byte = i_rd_data[15:8];
      2'd2:    w_byte = i_rd_data[23:16];
      default: w_byte = i_rd_data[31:24];
    endcase
    case (i_width)
      DBUS_BYTE: begin
        o_bytesel = 4'b0001 << i_addr_lo;
        o_wr_val  = {4{i_wr_val[7:0]}};
        o_rd_val  = {{24{i_signed & w_byte[7]}}, w_byte};
      end
      DBUS_HALF: begin
        o_bytesel  = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wr_val   = {2{i_wr_val[15:0]}};
        o_rd_val   = {{16{i_signed & w_half[15]}}, w_half};
        o_misalign = i_addr_lo[0];
      end
      DBUS_WORD: begin
        o_bytesel  = 4'b1111;
        o_wr_val   = i_wr_val;
        o_rd_val   = i_rd_data;
        o_misalign = |i_addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/keynsham_dbus_master.sv
// keynsham_dbus_master: single-outstanding load/store initiator for the
// Keynsham data bus. IDLE -> ACCESS -> DONE, with faulty requests going
// straight to DONE. All d_* outputs are registered and zero outside ACCESS.
// Define KEYNSHAM_DBUS_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES
// unacknowledged cycles; otherwise ACCESS waits indefinitely.
module keynsham_dbus_master
  import keynsham_dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DBUS_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  keynsham_dbus_if.master   bus
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_cfg_check
    $error("keynsham_dbus_master: TIMEOUT_CYCLES out of range 1..65535");
  end

  dbus_state_t r_state, w_state_nxt;

  logic        r_wr;
  logic [1:0]  r_addr_lo;
  logic [1:0]  r_width;
  logic        r_signed;
  logic        r_rsp_err;
  logic [31:0] r_rsp_data;
  logic        r_d_access;
  logic [31:0] r_d_addr;
  logic [3:0]  r_d_bytesel;
  logic [31:0] r_d_wr_val;
  logic        r_d_wr_en;

  logic        w_idle;
  logic        w_access;
  logic        w_accept;
  logic        w_req_bad;
  logic        w_timeout;
  logic        w_leave_access;
  logic [1:0]  w_lane_addr;
  logic [1:0]  w_lane_width;
  logic        w_lane_signed;
  logic [3:0]  w_bytesel;
  logic [31:0] w_wr_val;
  logic [31:0] w_rd_val;
  logic        w_misalign;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_access = (r_state == ST_ACCESS);
  assign w_accept = w_idle && bus.req_valid;

  // Lanes see the live request while idle and the captured one afterwards
  assign w_lane_addr   = w_idle ? bus.req_addr[1:0] : r_addr_lo;
  assign w_lane_width  = w_idle ? bus.req_width     : r_width;
  assign w_lane_signed = w_idle ? bus.req_signed    : r_signed;

  keynsham_dbus_lanes u_lanes (
    .i_addr_lo  (w_lane_addr),
    .i_width    (w_lane_width),
    .i_signed   (w_lane_signed),
    .i_wr_val   (bus.req_wr_val),
    .i_rd_data  (bus.d_data),
    .o_bytesel  (w_bytesel),
    .o_wr_val   (w_wr_val),
    .o_rd_val   (w_rd_val),
    .o_misalign (w_misalign)
  );

  assign w_req_bad = (bus.req_width == DBUS_RSVD) || w_misalign;

`ifdef KEYNSHAM_DBUS_TIMEOUT_EN
  localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT_CYCLES);
  logic [15:0] r_tmo_cnt;

  // Count unacknowledged ACCESS cycles; held at zero outside ACCESS
  always_ff @(posedge clk) begin
    if (rst || !w_access) r_tmo_cnt <= '0;
    else if (!bus.d_ack)  r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  // An ack in the expiry cycle takes priority over the timeout
  assign w_timeout = w_access && !bus.d_ack && ((r_tmo_cnt + 16'd1) == LP_TIMEOUT);
`else
  assign w_timeout = 1'b0;
`endif

  assign w_leave_access = w_access && (bus.d_ack || w_timeout);

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (bus.req_valid) w_state_nxt = w_req_bad ? ST_DONE : ST_ACCESS;
      ST_ACCESS: if (w_leave_access) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture request fields needed for load extraction
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_wr      <= bus.req_wr;
      r_addr_lo <= bus.req_addr[1:0];
      r_width   <= bus.req_width;
      r_signed  <= bus.req_signed;
    end
  end

  // Registered bus outputs: loaded on a good accept, cleared on leaving ACCESS
  always_ff @(posedge clk) begin
    if (rst || w_leave_access) begin
      r_d_access  <= 1'b0;
      r_d_addr    <= '0;
      r_d_bytesel <= '0;
      r_d_wr_val  <= '0;
      r_d_wr_en   <= 1'b0;
    end else if (w_accept && !w_req_bad) begin
      r_d_access  <= 1'b1;
      r_d_addr    <= {bus.req_addr[31:2], 2'b00};
      r_d_bytesel <= w_bytesel;
      r_d_wr_val  <= bus.req_wr ? w_wr_val : '0;
      r_d_wr_en   <= bus.req_wr;
    end
  end

  // Response registers: valid only while in DONE, zero otherwise
  always_ff @(posedge clk) begin
    if (rst || r_state == ST_DONE) begin
      r_rsp_err  <= 1'b0;
      r_rsp_data <= '0;
    end else if (w_accept) begin
      r_rsp_err  <= w_req_bad;
      r_rsp_data <= '0;
    end else if (w_access && bus.d_ack) begin
      r_rsp_err  <= 1'b0;
      r_rsp_data <= r_wr ? '0 : w_rd_val;
    end else if (w_timeout) begin
      r_rsp_err  <= 1'b1;
      r_rsp_data <= '0;
    end
  end

  assign bus.req_ready = w_idle;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.d_access  = r_d_access;
  assign bus.d_addr    = r_d_addr;
  assign bus.d_bytesel = r_d_bytesel;
  assign bus.d_wr_val  = r_d_wr_val;
  assign bus.d_wr_en   = r_d_wr_en;

endmodule

// File: tb/tb_keynsham_dbus_master.sv
// tb_keynsham_dbus_master: scoreboard bench for keynsham_dbus_master.
// Expected responses are queued as requests are issued and popped when
// rsp_valid is seen; bus-side fields are checked directly. The timeout case
// runs when KEYNSHAM_DBUS_TIMEOUT_EN is defined.
module tb_keynsham_dbus_master;

`ifdef KEYNSHAM_DBUS_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 255;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q_exp[$];
  exp_t m_e;
  logic prev_acc = 1'b0;
  logic seen_acc = 1'b0;
  int   gap      = 0;

  keynsham_dbus_if bus ();

  keynsham_dbus_master #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response scoreboard
  always @(negedge clk) begin
    if (bus.rsp_valid) begin
      if (q_exp.size() == 0) begin
        check_eq("rsp_spurious", 32'(bus.rsp_valid), 32'd0);
      end else begin
        m_e = q_exp.pop_front();
        check_eq("rsp_err", 32'(bus.rsp_err), 32'(m_e.err));
        check_eq("rsp_data", bus.rsp_data, m_e.data);
      end
    end
  end

  // Idle gap between bus transactions
  always @(negedge clk) begin
    if (bus.d_access && !prev_acc && seen_acc)
      check_eq("acc_gap_ge2", 32'(gap >= 2), 32'd1);
    if (bus.d_access) begin
      gap      = 0;
      seen_acc = 1'b1;
    end else begin
      gap++;
    end
    prev_acc = bus.d_access;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.req_ready) check_eq("ready_wait", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic drive_req(input logic wr, input logic [31:0] addr, input logic [1:0] width,
                           input logic sgn, input logic [31:0] val);
    wait_ready();
    bus.req_wr     = wr;
    bus.req_addr   = addr;
    bus.req_width  = width;
    bus.req_signed = sgn;
    bus.req_wr_val = val;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
  endtask

  task automatic push_exp(input logic err, input logic [31:0] data);
    exp_t e;
    e.err  = err;
    e.data = data;
    q_exp.push_back(e);
  endtask

  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [1:0] width,
                        input logic sgn, input logic [31:0] val, input logic [31:0] rdata,
                        input int ack_dly, input logic exp_err, input logic [31:0] exp_data,
                        input logic [3:0] exp_bsel, input logic [31:0] exp_wv);
    push_exp(exp_err, exp_data);
    drive_req(wr, addr, width, sgn, val);
    if (exp_err) begin
      check_eq("err_no_access", 32'(bus.d_access), 32'd0);
      check_eq("err_rsp_1cyc", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk); #1;
    end else begin
      check_eq("acc_high", 32'(bus.d_access), 32'd1);
      check_eq("d_addr", bus.d_addr, addr & 32'hFFFF_FFFC);
      check_eq("d_bytesel", 32'(bus.d_bytesel), 32'(exp_bsel));
      check_eq("d_wr_en", 32'(bus.d_wr_en), 32'(wr));
      if (wr) check_eq("d_wr_val", bus.d_wr_val, exp_wv);
      for (int i = 0; i < ack_dly; i++) begin
        @(posedge clk); #1;
      end
      bus.d_data = rdata;
      bus.d_ack  = 1'b1;
      @(posedge clk); #1;
      bus.d_ack  = 1'b0;
      check_eq("ack_acc_drop", 32'(bus.d_access), 32'd0);
      check_eq("ack_rsp_next", 32'(bus.rsp_valid), 32'd1);
      @(posedge clk); #1;
    end
    check_eq("ready_after_rsp", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    bus.req_valid  = 1'b0;
    bus.req_wr     = 1'b0;
    bus.req_addr   = '0;
    bus.req_width  = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_wr_val = '0;
    bus.d_data     = '0;
    bus.d_ack      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_eq("rst_ready", 32'(bus.req_ready), 32'd1);
    check_eq("rst_access", 32'(bus.d_access), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_bytesel", 32'(bus.d_bytesel), 32'd0);
    check_eq("rst_wr_en", 32'(bus.d_wr_en), 32'd0);
    check_eq("rst_rsp_err", 32'(bus.rsp_err), 32'd0);

    //     wr    addr           width  sgn   val            rdata          dly err   exp_data       bsel     wv
    do_txn(1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0,         1,  1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF);
    do_txn(1'b0, 32'h0000_0203, 2'b00, 1'b1, 32'h0,         32'h8011_2233, 0,  1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
    do_txn(1'b0, 32'h0000_0203, 2'b00, 1'b0, 32'h0,         32'h8011_2233, 0,  1'b0, 32'h0000_0080, 4'b1000, 32'h0);
    do_txn(1'b1, 32'h0000_0302, 2'b01, 1'b0, 32'h0000_A5C3, 32'h0,         1,  1'b0, 32'h0,         4'b1100, 32'hA5C3_A5C3);
    do_txn(1'b0, 32'h0000_0000, 2'b01, 1'b1, 32'h0,         32'h1234_8001, 0,  1'b0, 32'hFFFF_8001, 4'b0011, 32'h0);
    do_txn(1'b0, 32'h0000_0002, 2'b01, 1'b1, 32'h0,         32'h1234_8001, 2,  1'b0, 32'h0000_1234, 4'b1100, 32'h0);
    do_txn(1'b0, 32'h0000_0001, 2'b00, 1'b0, 32'h0,         32'h0000_AB00, 0,  1'b0, 32'h0000_00AB, 4'b0010, 32'h0);
    do_txn(1'b1, 32'h0000_0012, 2'b00, 1'b0, 32'h0000_335A, 32'h0,         0,  1'b0, 32'h0,         4'b0100, 32'h5A5A_5A5A);
    do_txn(1'b0, 32'h0000_0104, 2'b10, 1'b0, 32'h0,         32'hCAFE_F00D, 3,  1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0);
    do_txn(1'b0, 32'h0000_0101, 2'b10, 1'b0, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 32'h0);
    do_txn(1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0,         32'h0,         0,  1'b1, 32'h0,         4'b0000, 32'h0);
    do_txn(1'b1, 32'h0000_0303, 2'b01, 1'b0, 32'h0000_1111, 32'h0,         0,  1'b1, 32'h0,         4'b0000, 32'h0);

    // Long wait without ack, then trailing ack into DONE and IDLE
`ifdef KEYNSHAM_DBUS_TIMEOUT_EN
    push_exp(1'b1, 32'h0);
    drive_req(1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 20 && bus.d_access; i++) begin
      cnt++;
      @(posedge clk); #1;
    end
    check_eq("tmo_access_cycles", 32'(cnt), 32'd4);
    check_eq("tmo_rsp_valid", 32'(bus.rsp_valid), 32'd1);
`else
    push_exp(1'b0, 32'h0BAD_F00D);
    drive_req(1'b0, 32'h0000_0500, 2'b10, 1'b0, 32'h0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.d_access) cnt++;
      @(posedge clk); #1;
    end
    check_eq("noack_access_held", 32'(cnt), 32'd12);
    bus.d_data = 32'h0BAD_F00D;
    bus.d_ack  = 1'b1;
    @(posedge clk); #1;
    check_eq("late_ack_rsp", 32'(bus.rsp_valid), 32'd1);
`endif
    bus.d_ack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.d_ack = 1'b0;
    check_eq("trail_no_rsp", 32'(bus.rsp_valid), 32'd0);
    check_eq("trail_no_access", 32'(bus.d_access), 32'd0);
    check_eq("trail_ready", 32'(bus.req_ready), 32'd1);

    // Reset during ACCESS, then an ack that must be ignored
    drive_req(1'b0, 32'h0000_0400, 2'b10, 1'b0, 32'h0);
    check_eq("rst_pre_access", 32'(bus.d_access), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("rst_drop_access", 32'(bus.d_access), 32'd0);
    check_eq("rst_no_rsp0", 32'(bus.rsp_valid), 32'd0);
    bus.d_data = 32'h5555_AAAA;
    bus.d_ack  = 1'b1;
    @(posedge clk); #1;
    bus.d_ack  = 1'b0;
    check_eq("rst_no_rsp1", 32'(bus.rsp_valid), 32'd0);
    check_eq("rst_ready_after", 32'(bus.req_ready), 32'd1);
    check_eq("rst_access_after", 32'(bus.d_access), 32'd0);

    // Normal traffic resumes after the reset
    do_txn(1'b0, 32'h0000_0600, 2'b10, 1'b0, 32'h0, 32'h1357_9BDF, 0, 1'b0, 32'h1357_9BDF, 4'b1111, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty", 32'(q_exp.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
